// File: rtl/calc_sequencer.sv
// Micro-sequencer that fetches 16-bit instructions and drives datapath register-file, ALU and data-memory controls.
// Handshake strobes and datapath selects are decoded from the current state, so acks and Halt_i act within the same cycle.
module calc_sequencer #(
    parameter int unsigned WDOG_MAX = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start_i,
    input  logic [7:0]  start_pc_i,
    output logic        busy_o,
    output logic        done_o,
    output logic        err_o,
    output logic        imem_req_o,
    output logic [7:0]  imem_addr_o,
    input  logic        imem_ack_i,
    input  logic [15:0] imem_data_i,
    output logic        dmem_req_o,
    output logic        dmem_we_o,
    input  logic        dmem_ack_i,
    output logic [1:0]  RegSel0_o,
    output logic [1:0]  RegSel1_o,
    output logic [2:0]  RegSrc_o,
    output logic [2:0]  ALUSel_o,
    output logic        RDOnly_o,
    input  logic        Halt_i
);

    localparam int unsigned PC_W    = 8;
    localparam int unsigned INSTR_W = 16;
    localparam int unsigned WDOG_W  = (WDOG_MAX < 1) ? 1 : $clog2(WDOG_MAX + 1);
    localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(WDOG_MAX);

    localparam logic [3:0] OP_NOP  = 4'd0;
    localparam logic [3:0] OP_MOV  = 4'd1;
    localparam logic [3:0] OP_ALU  = 4'd2;
    localparam logic [3:0] OP_LD   = 4'd3;
    localparam logic [3:0] OP_ST   = 4'd4;
    localparam logic [3:0] OP_JMP  = 4'd5;
    localparam logic [3:0] OP_HALT = 4'd6;

    localparam logic [2:0] SRC_R0  = 3'd0;
    localparam logic [2:0] SRC_EXT = 3'd4;
    localparam logic [2:0] SRC_ALU = 3'd7;
    localparam logic [2:0] ALU_OFF = 3'd0;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_EXEC,
        S_ALU_WAIT,
        S_MEM,
        S_HALTED
    } state_t;

    state_t              state_q, state_d;
    logic [PC_W-1:0]     pc_q, pc_d;
    logic [INSTR_W-1:0]  instr_q, instr_d;
    logic [WDOG_W-1:0]   wdog_q, wdog_d;
    logic                err_q, err_d;
    logic                done_q, done_d;

    logic [3:0]          op;
    logic [1:0]          rd;
    logic [1:0]          rs;
    logic [7:0]          imm;

    assign op  = instr_q[15:12];
    assign rd  = instr_q[11:10];
    assign rs  = instr_q[9:8];
    assign imm = instr_q[7:0];

    assign err_o       = err_q;
    assign done_o      = done_q;
    assign imem_addr_o = pc_q;

    // State and architectural registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            pc_q    <= '0;
            instr_q <= '0;
            wdog_q  <= '0;
            err_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            wdog_q  <= wdog_d;
            err_q   <= err_d;
            done_q  <= done_d;
        end
    end

    // Next-state and control decode
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        instr_d    = instr_q;
        wdog_d     = wdog_q;
        err_d      = err_q;
        done_d     = 1'b0;
        busy_o     = 1'b1;
        imem_req_o = 1'b0;
        dmem_req_o = 1'b0;
        dmem_we_o  = 1'b0;
        RegSel0_o  = 2'd0;
        RegSel1_o  = 2'd0;
        RegSrc_o   = SRC_R0;
        ALUSel_o   = ALU_OFF;
        RDOnly_o   = 1'b1;

        case (state_q)
            S_IDLE, S_HALTED: begin
                busy_o = 1'b0;
                if (start_i) begin
                    pc_d    = start_pc_i;
                    err_d   = 1'b0;
                    state_d = S_FETCH;
                end
            end

            S_FETCH: begin
                imem_req_o = 1'b1;
                if (imem_ack_i) begin
                    instr_d = imem_data_i;
                    pc_d    = pc_q + PC_W'(1);
                    state_d = S_EXEC;
                end
            end

            S_EXEC: begin
                state_d = S_FETCH;
                case (op)
                    OP_NOP: ;
                    OP_MOV: begin
                        RegSel0_o = rd;
                        RegSrc_o  = {1'b0, rs};
                        RDOnly_o  = 1'b0;
                    end
                    OP_ALU: begin
                        // A zero ALU selector means "ALU off", so the instruction degenerates to a NOP
                        if (imm[2:0] != ALU_OFF) begin
                            wdog_d  = '0;
                            state_d = S_ALU_WAIT;
                        end
                    end
                    OP_LD, OP_ST: state_d = S_MEM;
                    OP_JMP:       pc_d    = imm;
                    OP_HALT: begin
                        done_d  = 1'b1;
                        state_d = S_HALTED;
                    end
                    default: begin
                        err_d   = 1'b1;
                        state_d = S_IDLE;
                    end
                endcase
            end

            S_ALU_WAIT: begin
                // Abort cycle releases the datapath so no partial ALU result is written
                if (Halt_i && (wdog_q == WDOG_LAST)) begin
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    RegSel0_o = rd;
                    RegSel1_o = rs;
                    RegSrc_o  = SRC_ALU;
                    ALUSel_o  = imm[2:0];
                    RDOnly_o  = 1'b0;
                    if (!Halt_i) begin
                        state_d = S_FETCH;
                    end else begin
                        wdog_d = wdog_q + WDOG_W'(1);
                    end
                end
            end

            S_MEM: begin
                dmem_req_o = 1'b1;
                dmem_we_o  = (op == OP_ST);
                RegSel0_o  = rd;
                RegSel1_o  = rs;
                if (dmem_ack_i) begin
                    if (op == OP_LD) begin
                        RegSrc_o = SRC_EXT;
                        RDOnly_o = 1'b0;
                    end
                    state_d = S_FETCH;
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_calc_sequencer.sv
// Bench for calc_sequencer: directed scenarios plus a random instruction stream checked against an
// instruction-level model of the expected handshake and datapath control trace.
module tb_calc_sequencer;

    localparam int unsigned WDOG = 15;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_i;
    logic [7:0]  start_pc_i;
    logic        busy_o;
    logic        done_o;
    logic        err_o;
    logic        imem_req_o;
    logic [7:0]  imem_addr_o;
    logic        imem_ack_i;
    logic [15:0] imem_data_i;
    logic        dmem_req_o;
    logic        dmem_we_o;
    logic        dmem_ack_i;
    logic [1:0]  RegSel0_o;
    logic [1:0]  RegSel1_o;
    logic [2:0]  RegSrc_o;
    logic [2:0]  ALUSel_o;
    logic        RDOnly_o;
    logic        Halt_i;

    logic [10:0] dp_obs;
    logic [10:0] dp_def;
    logic [7:0]  mpc;
    int          n_cmp = 0;
    int          n_mis = 0;

    always #5 clk = ~clk;

    calc_sequencer #(.WDOG_MAX(WDOG)) dut (
        .clk         (clk),
        .rst         (rst),
        .start_i     (start_i),
        .start_pc_i  (start_pc_i),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .err_o       (err_o),
        .imem_req_o  (imem_req_o),
        .imem_addr_o (imem_addr_o),
        .imem_ack_i  (imem_ack_i),
        .imem_data_i (imem_data_i),
        .dmem_req_o  (dmem_req_o),
        .dmem_we_o   (dmem_we_o),
        .dmem_ack_i  (dmem_ack_i),
        .RegSel0_o   (RegSel0_o),
        .RegSel1_o   (RegSel1_o),
        .RegSrc_o    (RegSrc_o),
        .ALUSel_o    (ALUSel_o),
        .RDOnly_o    (RDOnly_o),
        .Halt_i      (Halt_i)
    );

    assign dp_obs = {RegSel0_o, RegSel1_o, RegSrc_o, ALUSel_o, RDOnly_o};

    function automatic logic [10:0] dpv(input logic [1:0] s0, input logic [1:0] s1,
                                        input logic [2:0] src, input logic [2:0] alu,
                                        input logic rdo);
        return {s0, s1, src, alu, rdo};
    endfunction

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #3;
    endtask

    // Inputs that the sequencer must ignore in EXEC / ALU_WAIT
    task automatic noise();
        start_i    = 1'($urandom);
        start_pc_i = 8'($urandom);
        imem_ack_i = 1'($urandom);
        dmem_ack_i = 1'($urandom);
    endtask

    task automatic quiet();
        start_i    = 1'b0;
        imem_ack_i = 1'b0;
        dmem_ack_i = 1'b0;
    endtask

    task automatic do_start(input logic [7:0] pc);
        start_i    = 1'b1;
        start_pc_i = pc;
        settle();
        chk("start_busy", 16'(busy_o), 16'd0);
        tick();
        start_i = 1'b0;
        mpc     = pc;
        chk("start_err_clr", 16'(err_o), 16'd0);
    endtask

    task automatic do_fetch(input logic [15:0] instr, input int waits);
        for (int i = 0; i <= waits; i++) begin
            imem_ack_i  = (i == waits);
            imem_data_i = (i == waits) ? instr : 16'($urandom);
            settle();
            chk("fetch_req", 16'(imem_req_o), 16'd1);
            chk("fetch_addr", 16'(imem_addr_o), 16'(mpc));
            chk("fetch_busy", 16'(busy_o), 16'd1);
            chk("fetch_dp", 16'(dp_obs), 16'(dp_def));
            tick();
        end
        imem_ack_i = 1'b0;
        mpc        = mpc + 8'd1;
    endtask

    task automatic alu_wait(input logic [1:0] rd, input logic [1:0] rs, input logic [2:0] a,
                            input int hw);
        for (int i = 0; i <= hw; i++) begin
            noise();
            Halt_i = (i < hw);
            settle();
            chk("alu_dp", 16'(dp_obs), 16'(dpv(rd, rs, 3'd7, a, 1'b0)));
            chk("alu_busy", 16'(busy_o), 16'd1);
            tick();
        end
        Halt_i = 1'b0;
        quiet();
    endtask

    task automatic alu_stuck(input logic [1:0] rd, input logic [1:0] rs, input logic [2:0] a);
        for (int i = 0; i <= int'(WDOG); i++) begin
            Halt_i = 1'b1;
            settle();
            if (i < int'(WDOG))
                chk("wdog_dp_hold", 16'(dp_obs), 16'(dpv(rd, rs, 3'd7, a, 1'b0)));
            else
                chk("wdog_dp_abort", 16'(dp_obs), 16'(dp_def));
            tick();
        end
        Halt_i = 1'b0;
        settle();
        chk("wdog_err", 16'(err_o), 16'd1);
        chk("wdog_idle", 16'(busy_o), 16'd0);
        chk("wdog_alusel", 16'(ALUSel_o), 16'd0);
    endtask

    task automatic mem_phase(input logic is_st, input logic [1:0] rd, input logic [1:0] rs,
                             input int mw);
        for (int i = 0; i <= mw; i++) begin
            logic wr;
            dmem_ack_i = (i == mw);
            wr         = !is_st && (i == mw);
            settle();
            chk("mem_req", 16'(dmem_req_o), 16'd1);
            chk("mem_we", 16'(dmem_we_o), 16'(is_st));
            chk("mem_dp", 16'(dp_obs), 16'(dpv(rd, rs, wr ? 3'd4 : 3'd0, 3'd0, !wr)));
            tick();
        end
        dmem_ack_i = 1'b0;
    endtask

    // One instruction: fetch with fw wait cycles, ALU busy for hw cycles (hw > WDOG = stuck), mw dmem waits
    task automatic run(input logic [15:0] instr, input int fw, input int hw, input int mw);
        logic [3:0] op;
        logic [1:0] rd;
        logic [1:0] rs;
        logic [7:0] imm;
        op  = instr[15:12];
        rd  = instr[11:10];
        rs  = instr[9:8];
        imm = instr[7:0];
        do_fetch(instr, fw);
        noise();
        settle();
        chk("exec_req", 16'({imem_req_o, dmem_req_o}), 16'd0);
        chk("exec_done", 16'(done_o), 16'd0);
        if (op == 4'd1)
            chk("mov_dp", 16'(dp_obs), 16'(dpv(rd, 2'd0, {1'b0, rs}, 3'd0, 1'b0)));
        else
            chk("exec_dp", 16'(dp_obs), 16'(dp_def));
        tick();
        quiet();
        case (op)
            4'd0, 4'd1: ;
            4'd2: begin
                if (imm[2:0] != 3'd0) begin
                    if (hw > int'(WDOG)) alu_stuck(rd, rs, imm[2:0]);
                    else                 alu_wait(rd, rs, imm[2:0], hw);
                end
            end
            4'd3:    mem_phase(1'b0, rd, rs, mw);
            4'd4:    mem_phase(1'b1, rd, rs, mw);
            4'd5:    mpc = imm;
            4'd6: begin
                settle();
                chk("halt_done", 16'(done_o), 16'd1);
                chk("halt_busy", 16'(busy_o), 16'd0);
                tick();
                settle();
                chk("halt_done_pulse", 16'(done_o), 16'd0);
                chk("halt_busy2", 16'(busy_o), 16'd0);
            end
            default: begin
                settle();
                chk("illegal_err", 16'(err_o), 16'd1);
                chk("illegal_idle", 16'(busy_o), 16'd0);
                chk("illegal_req", 16'({imem_req_o, dmem_req_o}), 16'd0);
            end
        endcase
    endtask

    initial begin
        dp_def      = dpv(2'd0, 2'd0, 3'd0, 3'd0, 1'b1);
        rst         = 1'b1;
        start_i     = 1'b0;
        start_pc_i  = 8'd0;
        imem_ack_i  = 1'b0;
        imem_data_i = 16'd0;
        dmem_ack_i  = 1'b0;
        Halt_i      = 1'b0;
        mpc         = 8'd0;
        tick();
        tick();
        rst = 1'b0;
        settle();
        chk("rst_busy", 16'(busy_o), 16'd0);
        chk("rst_reqs", 16'({imem_req_o, dmem_req_o}), 16'd0);
        chk("rst_err_done", 16'({err_o, done_o}), 16'd0);
        chk("rst_dp", 16'(dp_obs), 16'(dp_def));
        chk("rst_pc", 16'(imem_addr_o), 16'd0);

        // MOV with slow fetch, ALU, LD/ST, zero-op ALU
        do_start(8'h10);
        run(16'h1100, 2, 0, 0);
        run(16'h2103, 0, 3, 0);
        run(16'h3100, 1, 0, 1);
        run(16'h4100, 0, 0, 2);
        run(16'h2D08, 0, 0, 0);

        // PC wrap, jump, halt, restart from HALTED
        run(16'h50FF, 0, 0, 0);
        run(16'h0000, 1, 0, 0);
        run(16'h5042, 0, 0, 0);
        run(16'h6000, 0, 0, 0);
        do_start(8'h42);
        run(16'h2E05, 0, int'(WDOG), 0);

        // Watchdog abort then illegal opcode
        run(16'h2103, 0, int'(WDOG) + 1, 0);
        do_start(8'h80);
        run(16'hF000, 0, 0, 0);
        do_start(8'h81);
        run(16'h7ABC, 2, 0, 0);

        // Reset mid data handshake
        do_start(8'h20);
        do_fetch(16'h3100, 0);
        settle();
        tick();
        settle();
        chk("rst_mem_req_pre", 16'(dmem_req_o), 16'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        settle();
        chk("rst_mem_req", 16'(dmem_req_o), 16'd0);
        chk("rst_mem_busy", 16'(busy_o), 16'd0);
        chk("rst_mem_dp", 16'(dp_obs), 16'(dp_def));
        chk("rst_mem_pc", 16'(imem_addr_o), 16'd0);
        chk("rst_mem_flags", 16'({imem_req_o, err_o, done_o}), 16'd0);

        // Random instruction stream
        do_start(8'($urandom));
        for (int n = 0; n < 80; n++) begin
            logic [15:0] ins;
            ins = {4'($urandom_range(0, 5)), 12'($urandom)};
            run(ins, $urandom_range(0, 3), $urandom_range(0, WDOG), $urandom_range(0, 3));
        end
        run({4'($urandom_range(7, 15)), 12'($urandom)}, 1, 0, 0);
        do_start(8'($urandom));
        run(16'h6000, 0, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/calc_sequencer.md
CALC_SEQUENCER -- requirements
Module: calc_sequencer

Interface
REQ-001 The block SHALL have one clock and reset that is synchronous and active-high; all state SHALL update on the rising clk edge only.
REQ-002 Parameter WDOG_MAX, default 15: maximum cycles to wait for ALU completion before abort.
REQ-003 Ports SHALL be:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- start_i  in  1  begin execution at start_pc_i (IDLE/HALTED only)
- start_pc_i  in  8  initial fetch address
- busy_o  out  1  high in any state except IDLE/HALTED
- done_o  out  1  one-cycle pulse on HALT instruction
- err_o  out  1  sticky error; cleared by start_i or rst
- imem_req_o  out  1  instruction fetch request
- imem_addr_o  out  8  fetch address (= pc)
- imem_ack_i  in  1  fetch data valid
- imem_data_i  in  16  instruction word
- dmem_req_o  out  1  data access request
- dmem_we_o  out  1  1 = store, 0 = load
- dmem_ack_i  in  1  data access complete (load data valid on ExternVal)
- RegSel0_o  out  2  datapath destination/ALU operand 0 select
- RegSel1_o  out  2  datapath operand 1 / address select
- RegSrc_o  out  3  register write source (0 r0, 1 r1, 2 PC, 3 LR, 4 extern, 7 ALU)
- ALUSel_o  out  3  ALU operation; 0 = ALU off
- RDOnly_o  out  1  1 = no register write
- Halt_i  in  1  datapath ALU busy

Function
REQ-004 Instruction format: [15:12] op, [11:10] rd, [9:8] rs, [7:0] imm.
REQ-005 Opcodes: 0 NOP; 1 MOV rd<-rs; 2 ALU rd<-rd op rs, op = imm[2:0]; 3 LD rd<-mem[rs]; 4 ST mem[rs]<-rd; 5 JMP pc<-imm; 6 HALT; 7-15 illegal.
REQ-006 States: IDLE, FETCH, EXEC, ALU_WAIT, MEM, HALTED.
REQ-007 Datapath defaults in every cycle not listed below: RegSel0=0, RegSel1=0, RegSrc=0, ALUSel=0, RDOnly=1.
REQ-008 IDLE/HALTED + start_i: pc<=start_pc_i, err_o<=0, go FETCH.
REQ-009 FETCH: imem_req_o=1 held until imem_ack_i; on ack latch instr, pc<=pc+1 mod 256 (255 wraps to 0), go EXEC.
REQ-010 EXEC, NOP: no write, go FETCH; JMP: pc<=imm, go FETCH.
REQ-011 EXEC, MOV: one cycle RegSel0=rd, RegSrc={1'b0,rs}, RDOnly=0, then FETCH.
REQ-012 EXEC, ALU with imm[2:0]!=0: go ALU_WAIT; imm[2:0]==0 SHALL behave as NOP.
REQ-013 ALU_WAIT: drive RegSel0=rd, RegSel1=rs, RegSrc=7, ALUSel=imm[2:0], RDOnly=0; leave for FETCH in the first cycle Halt_i=0 (register write occurs in that cycle).
REQ-014 ALU_WAIT watchdog: counter reset on entry; if Halt_i=1 for WDOG_MAX+1 consecutive cycles, set err_o, drive defaults, go IDLE.
REQ-015 EXEC, LD/ST: go MEM. MEM: dmem_req_o=1, dmem_we_o=(op==ST), RegSel1=rs, RegSel0=rd, held until dmem_ack_i.
REQ-016 MEM, LD: RegSrc=4 and RDOnly=0 only in the dmem_ack_i cycle; RDOnly=1 otherwise. ST: RDOnly=1 throughout.
REQ-017 On dmem_ack_i go FETCH; no timeout on imem/dmem.
REQ-018 HALT: done_o=1 for one cycle, go HALTED; illegal op: err_o<=1, go IDLE.
REQ-019 start_i ignored while busy_o=1; ack inputs ignored outside FETCH/MEM.

Reset
REQ-020 rst SHALL, from any state including mid-handshake, force IDLE, pc=0, err_o=0, done_o=0, busy_o=0, imem_req_o=0, dmem_req_o=0 and datapath defaults (REQ-007) on the next edge.

Verification
REQ-021 start_pc=0x10, imem returns 0x1100 (MOV r0<-r1), ack after 2 wait cycles -> req held 3 cycles, one write cycle RegSel0=0 RegSrc=1 RDOnly=0, next fetch addr 0x11.
REQ-022 ALU 0x2103 with Halt_i high 3 cycles -> ALUSel=3 held 4 cycles, exit on Halt_i=0, then FETCH.
REQ-023 Halt_i stuck high -> after 16 ALU_WAIT cycles err_o=1, ALUSel=0, state IDLE.
REQ-024 LD 0x3100 with dmem ack after 1 wait -> dmem_we=0, RDOnly=0 and RegSrc=4 only in ack cycle; ST 0x4100 -> dmem_we=1, RDOnly=1 throughout.
REQ-025 Fetch at pc=0xFF of NOP -> next fetch addr 0x00; JMP 0x5042 -> next fetch 0x42; HALT 0x6000 -> done_o single pulse, busy_o=0.
REQ-026 rst asserted during MEM with dmem_req_o=1 -> next cycle dmem_req_o=0, busy_o=0, all outputs at reset values; opcode 0xF000 -> err_o=1, IDLE.
